// File: rtl/mips_multi_cycle.sv
// mips_multi_cycle: parametrised multi-cycle 16-bit-ISA core (FETCH/DECODE/EXEC/MEM/WB)
// Ports:
//   clk, rst           clock (rising edge), synchronous active-high reset
//   o_imem_addr        instruction address (= pc); i_imem_rdata valid combinationally in FETCH
//   o_dmem_req/we/addr/wdata, i_dmem_rdata, i_dmem_ack   data memory req/ack handshake
//   i_dbg_sel, o_dbg_data   combinational register debug read
//   o_pc_out, o_alu_out     current pc, registered result of last EXEC
//   o_retire, o_halted      completion pulse (final cycle of each instruction), HALT state flag
module mips_multi_cycle #(
    parameter int DW   = 8,
    parameter int NREG = 4,
    parameter int PW   = 8,
    parameter int AW   = 3
) (
    input  logic          clk,
    input  logic          rst,
    output logic [PW-1:0] o_imem_addr,
    input  logic [15:0]   i_imem_rdata,
    output logic          o_dmem_req,
    output logic          o_dmem_we,
    output logic [AW-1:0] o_dmem_addr,
    output logic [DW-1:0] o_dmem_wdata,
    input  logic [DW-1:0] i_dmem_rdata,
    input  logic          i_dmem_ack,
    input  logic [3:0]    i_dbg_sel,
    output logic [DW-1:0] o_dbg_data,
    output logic [PW-1:0] o_pc_out,
    output logic [DW-1:0] o_alu_out,
    output logic          o_retire,
    output logic          o_halted
);
    localparam int RW = $clog2(NREG);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t        r_state, w_next;
    logic [PW-1:0] r_pc, w_pc_next;
    logic [15:0]   r_ir;
    logic [DW-1:0] r_a, r_b, r_d, r_alu, r_ld, w_alu, w_simm;
    logic [DW-1:0] r_regs [NREG];
    logic [3:0]    w_op;
    logic [RW-1:0] w_rd, w_rs, w_rt;
    logic          w_mem, w_no_wb, w_halt, w_unused;

    assign w_op    = r_ir[15:12];
    assign w_rd    = r_ir[8 +: RW];
    assign w_rs    = r_ir[4 +: RW];
    assign w_rt    = r_ir[0 +: RW];
    assign w_simm  = DW'($signed(r_ir[3:0]));
    assign w_mem   = (w_op == 4'h3) || (w_op == 4'h4);
    // JMP, BEQ and B..E finish in EXEC without a register write
    assign w_no_wb = (w_op == 4'h5) || (w_op == 4'h9) || (w_op >= 4'hB && w_op <= 4'hE);
    assign w_halt  = (w_op == 4'hF);
    assign w_unused = ^i_dbg_sel;

    assign w_pc_next = (w_op == 4'h5) ? PW'(r_ir[11:0]) :
                       (w_op == 4'h9 && r_d == r_a) ? r_pc + PW'(1) + PW'($signed(r_ir[3:0])) :
                       r_pc + PW'(1);

    always_comb begin
        w_alu = r_a + r_b;
        case (w_op)
            4'h1:             w_alu = r_a - r_b;
            4'h2, 4'h3, 4'h4: w_alu = r_a + w_simm;
            4'h6:             w_alu = r_a ^ r_b;
            4'h7:             w_alu = r_a | r_b;
            4'h8:             w_alu = r_a & r_b;
            4'hA:             w_alu = DW'($signed(r_a) < $signed(r_b));
            default:          w_alu = r_a + r_b;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    // FSM: next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: w_next = S_EXEC;
            S_EXEC:   w_next = w_halt ? S_HALT : w_mem ? S_MEM : w_no_wb ? S_FETCH : S_WB;
            S_MEM:    w_next = !i_dmem_ack ? S_MEM : (w_op == 4'h3) ? S_WB : S_FETCH;
            S_WB:     w_next = S_FETCH;
            default:  w_next = S_HALT;
        endcase
    end

    // FSM: outputs; address/data come from registers so they hold steady through the wait
    always_comb begin
        o_dmem_req   = (r_state == S_MEM);
        o_dmem_we    = o_dmem_req && (w_op == 4'h4);
        o_dmem_addr  = r_alu[AW-1:0];
        o_dmem_wdata = r_d;
        o_halted     = (r_state == S_HALT);
        o_retire     = (r_state == S_WB) ||
                       (r_state == S_EXEC && w_no_wb) ||
                       (r_state == S_MEM && i_dmem_ack && w_op == 4'h4);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc  <= '0;
            r_ir  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_d   <= '0;
            r_alu <= '0;
            r_ld  <= '0;
            for (int i = 0; i < NREG; i++) r_regs[i] <= DW'(i);
        end else begin
            case (r_state)
                S_FETCH: r_ir <= i_imem_rdata;
                S_DECODE: begin
                    r_a <= r_regs[w_rs];
                    r_b <= r_regs[w_rt];
                    r_d <= r_regs[w_rd];
                end
                S_EXEC: begin
                    r_alu <= w_alu;
                    if (w_no_wb) r_pc <= w_pc_next;
                end
                S_MEM: begin
                    if (i_dmem_ack) r_ld <= i_dmem_rdata;
                    if (i_dmem_ack && w_op == 4'h4) r_pc <= r_pc + PW'(1);
                end
                S_WB: begin
                    r_regs[w_rd] <= (w_op == 4'h3) ? r_ld : r_alu;
                    r_pc         <= r_pc + PW'(1);
                end
                default: ;
            endcase
        end
    end

    assign o_imem_addr = r_pc;
    assign o_pc_out    = r_pc;
    assign o_alu_out   = r_alu;
    assign o_dbg_data  = r_regs[i_dbg_sel[RW-1:0]];
endmodule
